// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//
// Sequential wide adder: adds two WIDTH-bit unsigned operands one 4-bit
// nibble per clock through a single 4-bit add step, carrying between
// nibbles through a registered carry. Valid/ready handshakes on both sides.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a, b, cin are valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       WIDTH-bit operands
//   cin        carry into nibble 0
//   out_valid  sum/cout are valid (DONE only)
//   out_ready  consumer accepts the result
//   sum        (a + b + cin) mod 2^WIDTH
//   cout       carry out of the most significant nibble
//   busy       high while an addition is in RUN or waiting in DONE
//
// WIDTH must be a multiple of 4 and at least 4.

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  res_sh;
    logic [WIDTH-1:0]  res_next;
    logic              carry_reg;
    logic [CNT_W-1:0]  cnt;
    logic [4:0]        step;

    // One nibble of the ripple datapath: 4-bit sum in [3:0], carry in [4].
    function automatic logic [4:0] nib_add(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       c);
        return {1'b0, x} + {1'b0, y} + {4'b0000, c};
    endfunction

    assign step = nib_add(a_sh[3:0], b_sh[3:0], carry_reg);

    // Each new sum nibble enters at the top; after NIB steps nibble 0 has
    // reached the bottom and the register holds the full result in order.
    assign res_next = (res_sh >> 4) | (WIDTH'(step[3:0]) << (WIDTH - 4));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand shifters, carry, counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_sh      <= a;
            b_sh      <= b;
            res_sh    <= '0;
            carry_reg <= cin;
            cnt       <= '0;
        end else if (state == RUN) begin
            a_sh      <= a_sh >> 4;
            b_sh      <= b_sh >> 4;
            res_sh    <= res_next;
            carry_reg <= step[4];
            cnt       <= cnt + CNT_W'(1);
            // Outputs change only on the last step, so a partial result
            // is never visible on sum/cout.
            if (cnt == LAST) begin
                sum  <= res_next;
                cout <= step[4];
            end
        end
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequential wide adder that adds two WIDTH-bit operands one 4-bit nibble per clock.
- Each cycle it forms a 4-bit sum plus carry from one nibble of each operand and the registered carry.
- Sits as the operand sequencer and result collector around the team's 4-bit ripple-carry datapath, giving wide additions at 4-bit-adder cost.
- Valid/ready handshake on both the input and the output side.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4 (derived, not overridable), number of nibble steps per addition.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; sum=0; cout=0.
  - Internal shift registers, carry register and nibble counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b, cin; clear counter; go to RUN.
  - in_valid low: stay in IDLE.
- RUN:
  - in_ready=0; busy=1.
  - Each cycle: {c_n, s_n} = a_sh[3:0] + b_sh[3:0] + carry_reg.
  - s_n shifts into the top of the result shift register, which shifts right by 4.
  - a_sh and b_sh shift right by 4; carry_reg <= c_n; counter increments.
  - After exactly NIB RUN cycles: go to DONE, load sum and cout.
  - in_valid during RUN is ignored and no operands are captured.
- DONE:
  - out_valid=1; in_ready=0.
  - sum and cout stay stable for as long as out_ready is low.
  - On out_valid&&out_ready: go to IDLE. out_valid drops the next cycle and in_ready rises the next cycle.
  - There is no same-cycle accept of new operands on DONE exit.
- Latency:
  - Accept edge = cycle 0; out_valid is high from edge NIB (4 for WIDTH=16).
  - Minimum issue interval is NIB+2 cycles.
- Arithmetic: unsigned. sum = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
  - Carry propagates between nibbles only through carry_reg.
- Outputs after handshake: sum and cout keep their last value until the next DONE load, but are meaningful only while out_valid is high.
- Reset mid-operation: any state aborts immediately to the reset values. No partial result is ever presented.
- in_valid and out_ready may be high at any time. Only the state-qualified handshakes above have any effect.

Test Plan:
- WIDTH=16; a=0x0008, b=0x0007, cin=0, out_ready=1 -> out_valid asserted 4 cycles after accept; sum=0x000F, cout=0; in_ready returns high 1 cycle after the output handshake.
- a=0x000B, b=0x0005, cin=0 -> sum=0x0010, cout=0 (carry crosses from nibble 0 to nibble 1).
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (full ripple through all nibbles). Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Backpressure: a=0x1234, b=0x4321, out_ready held low for 6 cycles in DONE, in_valid held high with new operands throughout:
  - sum=0x5555 stable and out_valid high the whole time;
  - in_ready stays 0 and no capture occurs;
  - after out_ready=1, the next operands are accepted 1 cycle after IDLE is re-entered.
- Reset mid-RUN: accept a=0x8888, b=0x8888, then assert rst_n=0 after 2 RUN cycles -> out_valid=0, sum=0, cout=0 immediately. After release, a=0x8888, b=0x8888 -> sum=0x1110, cout=1.
- Randomised back-to-back: 200 random a/b/cin with random out_ready stalls -> every result matches the reference a+b+cin model; each accepted input produces exactly one output handshake.
